// File: rtl/driver_config_sequencer.sv
// Function-control configuration sequencer for a daisy-chain of LED drivers.
// Writes FCWRTEN then the FC word into every driver, then hands the lines to the streaming controller.
module driver_config_sequencer #(
    parameter int DATA_WIDTH  = 48,
    parameter int NB_DRIVERS  = 2,
    parameter int FCWRTEN_LEN = 15,
    parameter int WRTFC_LEN   = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  stream_sin,
    input  logic                  stream_lat,
    input  logic                  stream_sclk,
    output logic                  sin,
    output logic                  lat,
    output logic                  sclk,
    output logic                  stream_nrst,
    output logic                  busy,
    output logic                  done
);

    localparam int SHIFT_LEN = NB_DRIVERS * DATA_WIDTH;
    localparam int SH_W      = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam int BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAP_A_LEN = 4;
    localparam int PH_MAX    = (FCWRTEN_LEN > GAP_A_LEN) ? FCWRTEN_LEN : GAP_A_LEN;
    localparam int PH_W      = $clog2(PH_MAX);
    localparam int LAT_FROM  = SHIFT_LEN - WRTFC_LEN;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GAP_A   = 3'd1;
    localparam logic [2:0] ST_FCWRTEN = 3'd2;
    localparam logic [2:0] ST_GAP_B   = 3'd3;
    localparam logic [2:0] ST_SHIFT   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_STREAM  = 3'd6;

    logic [2:0]            state_q,     state_d;
    logic [PH_W-1:0]       ph_cnt_q,    ph_cnt_d;
    logic [SH_W-1:0]       shift_cnt_q, shift_cnt_d;
    logic [BIT_W-1:0]      bit_idx_q,   bit_idx_d;
    logic [DATA_WIDTH-1:0] word_q,      word_d;
    logic                  sin_q,       sin_d;
    logic                  lat_q,       lat_d;
    logic                  sclk_en_q,   sclk_en_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  pass_s;

    // Sequencing: phase lengths, bit position and word capture.
    always_comb begin
        state_d     = state_q;
        ph_cnt_d    = ph_cnt_q;
        shift_cnt_d = shift_cnt_q;
        bit_idx_d   = bit_idx_q;
        word_d      = word_q;
        case (state_q)
            ST_IDLE: begin
                state_d  = ST_GAP_A;
                ph_cnt_d = {PH_W{1'b0}};
                word_d   = cfg_data;
            end
            ST_GAP_A: begin
                if (ph_cnt_q == PH_W'(GAP_A_LEN - 1)) begin
                    state_d  = ST_FCWRTEN;
                    ph_cnt_d = {PH_W{1'b0}};
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_FCWRTEN: begin
                if (ph_cnt_q == PH_W'(FCWRTEN_LEN - 1)) begin
                    state_d  = ST_GAP_B;
                    ph_cnt_d = {PH_W{1'b0}};
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_GAP_B: begin
                state_d     = ST_SHIFT;
                shift_cnt_d = {SH_W{1'b0}};
                bit_idx_d   = {BIT_W{1'b0}};
            end
            ST_SHIFT: begin
                if (shift_cnt_q == SH_W'(SHIFT_LEN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SH_W'(1);
                    // Every driver receives the same word, so the bit index restarts per driver.
                    if (bit_idx_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_idx_d = {BIT_W{1'b0}};
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (cfg_start) begin
                    state_d  = ST_GAP_A;
                    ph_cnt_d = {PH_W{1'b0}};
                    word_d   = cfg_data;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line values for the state being entered, so the registers line up with the state.
    always_comb begin
        sin_d     = 1'b0;
        lat_d     = 1'b0;
        sclk_en_d = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        case (state_d)
            ST_FCWRTEN: begin
                lat_d     = 1'b1;
                sclk_en_d = 1'b1;
            end
            ST_SHIFT: begin
                sclk_en_d = 1'b1;
                sin_d     = word_d[BIT_W'(DATA_WIDTH - 1) - bit_idx_d];
                lat_d     = (shift_cnt_d >= SH_W'(LAT_FROM)) ? 1'b1 : 1'b0;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            ST_STREAM: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // State, counters, captured word and registered line drivers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            ph_cnt_q    <= {PH_W{1'b0}};
            shift_cnt_q <= {SH_W{1'b0}};
            bit_idx_q   <= {BIT_W{1'b0}};
            word_q      <= {DATA_WIDTH{1'b0}};
            sin_q       <= 1'b0;
            lat_q       <= 1'b0;
            sclk_en_q   <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            shift_cnt_q <= shift_cnt_d;
            bit_idx_q   <= bit_idx_d;
            word_q      <= word_d;
            sin_q       <= sin_d;
            lat_q       <= lat_d;
            sclk_en_q   <= sclk_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // A restart request takes the lines back in the very cycle it arrives.
    assign pass_s      = (state_q == ST_STREAM) && !cfg_start;
    assign stream_nrst = pass_s;
    assign sin         = pass_s ? stream_sin  : sin_q;
    assign lat         = pass_s ? stream_lat  : lat_q;
    assign sclk        = pass_s ? stream_sclk : (clk & sclk_en_q);
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_driver_config_sequencer.sv
// Randomized directed bench for driver_config_sequencer against a cycle-table reference model.
module tb_driver_config_sequencer;

    localparam int DW      = 48;
    localparam int NB      = 2;
    localparam int FL      = 15;
    localparam int WL      = 5;
    localparam int NW      = NB * DW;
    localparam int SH0     = 5 + FL;
    localparam int SEQ_LEN = 4 + FL + 1 + NW + 1;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cfg_start;
    logic [DW-1:0] cfg_data;
    logic          stream_sin, stream_lat, stream_sclk;
    logic          sin, lat, sclk, stream_nrst, busy, done;

    int tests_run    = 0;
    int tests_failed = 0;

    driver_config_sequencer #(
        .DATA_WIDTH (DW),
        .NB_DRIVERS (NB),
        .FCWRTEN_LEN(FL),
        .WRTFC_LEN  (WL)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cfg_start  (cfg_start),
        .cfg_data   (cfg_data),
        .stream_sin (stream_sin),
        .stream_lat (stream_lat),
        .stream_sclk(stream_sclk),
        .sin        (sin),
        .lat        (lat),
        .sclk       (sclk),
        .stream_nrst(stream_nrst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic logic rand_bit();
        logic [31:0] r;
        r = $urandom();
        return r[0];
    endfunction

    // Expected {sin, lat, sclk, busy, done} k cycles into a configuration pass.
    function automatic logic [4:0] expect_at(input int k, input logic [DW-1:0] w);
        int s;
        if (k < 4)       return 5'b00010;
        if (k < 4 + FL)  return 5'b01110;
        if (k == 4 + FL) return 5'b00010;
        if (k < SH0 + NW) begin
            s = k - SH0;
            return {w[DW - 1 - (s % DW)], (s >= NW - WL) ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0};
        end
        return 5'b00011;
    endfunction

    task automatic run_seq(input logic [DW-1:0] word, input bit poke, input int abort_k);
        int            sclk_n     = 0;
        int            lat_sclk_n = 0;
        int            done_n     = 0;
        logic [NW-1:0] shifted    = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seq_k%0d", k), 128'({sin, lat, sclk, busy, done, stream_nrst}),
                128'({expect_at(k, word), 1'b0}));
            if (sclk) sclk_n++;
            if (sclk && lat) lat_sclk_n++;
            if (done) done_n++;
            if (k >= SH0 && k < SH0 + NW) shifted = {shifted[NW-2:0], sin};
            if (k == abort_k) begin
                @(negedge clk);
                nrst = 1'b0;
                #1;
                chk("abort_immediate", 128'({sin, lat, sclk, busy, done, stream_nrst}), 128'(6'b000100));
                @(posedge clk);
                #1;
                chk("abort_held", 128'({sin, lat, sclk, busy, done, stream_nrst}), 128'(6'b000100));
                return;
            end
            cfg_start   = poke && (k == 8 || k == SH0 + 30);
            cfg_data    = rand_word();
            stream_sin  = rand_bit();
            stream_lat  = rand_bit();
            stream_sclk = rand_bit();
        end
        chk("sclk_pulses", 128'(sclk_n), 128'(FL + NW));
        chk("lat_sclk_pulses", 128'(lat_sclk_n), 128'(FL + WL));
        chk("done_pulses", 128'(done_n), 128'(1));
        chk("shifted_word", 128'(shifted), 128'({word, word}));
    endtask

    task automatic stream_phase(input int n, input logic [DW-1:0] next_word);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            stream_sin  = rand_bit();
            stream_lat  = rand_bit();
            stream_sclk = rand_bit();
            #1;
            chk($sformatf("stream_pass_%0d", i),
                128'({sin, lat, sclk, stream_nrst, busy, done}),
                128'({stream_sin, stream_lat, stream_sclk, 1'b1, 1'b0, 1'b0}));
        end
        stream_sin  = 1'b1;
        stream_lat  = 1'b1;
        stream_sclk = 1'b1;
        cfg_data    = next_word;
        cfg_start   = 1'b1;
        #1;
        chk("stream_reclaim", 128'({sin, lat, sclk, stream_nrst}), 128'(4'b0000));
    endtask

    initial begin
        logic [DW-1:0] w1, w2, w3, w4, w5;
        nrst        = 1'b0;
        cfg_start   = 1'b0;
        cfg_data    = '0;
        stream_sin  = 1'b0;
        stream_lat  = 1'b0;
        stream_sclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 128'({sin, lat, sclk, busy, done, stream_nrst}), 128'(6'b000100));

        w1 = 48'hA5A5_0000_FFFF;
        cfg_data = w1;
        @(negedge clk);
        nrst = 1'b1;
        run_seq(w1, 1'b0, -1);

        w2 = rand_word();
        stream_phase(6, w2);
        run_seq(w2, 1'b1, -1);

        w3 = rand_word();
        stream_phase(4, w3);
        run_seq(w3, 1'b0, SH0 + 40);

        w4 = rand_word();
        cfg_data = w4;
        @(negedge clk);
        nrst = 1'b1;
        run_seq(w4, 1'b0, -1);

        w5 = rand_word();
        stream_phase(3, w5);
        run_seq(w5, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/driver_config_sequencer.md
DRIVER_CONFIG_SEQUENCER -- requirements
Module: driver_config_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48, bits per driver common shift register.
REQ-002 SHALL have parameter NB_DRIVERS, default 2, drivers daisy-chained on one SIN line.
REQ-003 SHALL have parameter FCWRTEN_LEN, default 15, LAT-high SCLK count for the FCWRTEN command.
REQ-004 SHALL have parameter WRTFC_LEN, default 5, LAT-high SCLK count for the WRTFC command.
REQ-005 SHALL have port clk  input  1  system clock; the single clock, all state on its rising edge.
REQ-006 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port cfg_start  input  1  one-cycle request to (re)write function-control data.
REQ-008 SHALL have port cfg_data  input  DATA_WIDTH  FC word, identical for every driver in the chain.
REQ-009 SHALL have ports stream_sin, stream_lat, stream_sclk  input  1 each  streaming driver-controller outputs.
REQ-010 SHALL have ports sin, lat, sclk  output  1 each  lines to the driver chain.
REQ-011 SHALL have port stream_nrst  output  1  active-low hold for the streaming controller.
REQ-012 SHALL have ports busy, done  output  1 each  configuration in progress; one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, GAP_A, FCWRTEN, GAP_B, SHIFT, DONE, STREAM.
REQ-014 SHALL leave IDLE for GAP_A on the first clk edge after reset release, with no cfg_start needed, using the cfg_data value present at that edge.
REQ-015 SHALL capture cfg_data into an internal register on every accepted start (IDLE exit, or cfg_start in STREAM).
REQ-016 SHALL hold GAP_A 4 cycles: sclk gated off, lat 0, sin 0, stream_nrst 0.
REQ-017 SHALL hold FCWRTEN exactly FCWRTEN_LEN cycles with sclk running, lat 1, sin 0.
REQ-018 SHALL hold GAP_B 1 cycle: sclk gated off, lat 0.
REQ-019 SHALL hold SHIFT exactly NB_DRIVERS*DATA_WIDTH cycles, sclk running, sin = captured word MSB first, repeated per driver.
REQ-020 SHALL drive lat 1 during the final WRTFC_LEN SHIFT cycles only; lat 0 earlier in SHIFT.
REQ-021 SHALL register sin, lat and the sclk enable; sclk SHALL equal clk AND the registered enable, so no partial pulse is ever produced.
REQ-022 SHALL size the SHIFT bit counter as $clog2(NB_DRIVERS*DATA_WIDTH) bits and wrap the per-driver bit index at DATA_WIDTH-1 to 0.
REQ-023 SHALL assert done for exactly the one DONE cycle, then enter STREAM.
REQ-024 SHALL assert busy in every state except STREAM.
REQ-025 SHALL, in STREAM, set stream_nrst 1 and pass stream_sin, stream_lat, stream_sclk combinationally to sin, lat, sclk.
REQ-026 SHALL, on cfg_start in STREAM, drop stream_nrst and reclaim sin/lat/sclk in the same cycle, then go to GAP_A.
REQ-027 SHALL ignore cfg_start in any state other than STREAM; no queuing.
REQ-028 SHALL not sample cfg_data changes after capture; the shifted word is the captured value.

Reset
REQ-029 SHALL, while nrst is 0, force IDLE, sin 0, lat 0, sclk enable 0, stream_nrst 0, busy 1, done 0, counters 0.
REQ-030 SHALL abort any sequence on mid-operation reset with no glitch on sclk and restart from REQ-014 after release.

Verification
REQ-031 SHALL cover: release reset, cfg_data=48'hA5A5_0000_FFFF -> 4 idle, 15 sclk with lat=1, 1 gap, 96 sclk with lat=1 on the last 5, done pulse, stream_nrst=1.
REQ-032 SHALL cover: SHIFT sin capture over 96 sclk -> 48'hA5A5_0000_FFFF twice, MSB first.
REQ-033 SHALL cover: cfg_start in STREAM -> passthrough stops and stream_nrst=0 in the same cycle; full sequence repeats with newly captured cfg_data.
REQ-034 SHALL cover: cfg_start pulses during FCWRTEN and SHIFT -> ignored; exactly one done pulse.
REQ-035 SHALL cover: nrst asserted at SHIFT bit 40 -> outputs reset immediately; after release a fresh sequence of exactly 15+96 sclk pulses.
REQ-036 SHALL cover: cfg_data changed during SHIFT -> shifted bits unchanged (captured word).
